// File: rtl/lookupflow_tbl.sv
// Flow-lookup engine: walks a DEPTH-entry masked dst-IP table one entry per cycle
// and returns the first matching entry's forward mask, or a miss error.
module lookupflow_tbl #(
  parameter int unsigned NPORT  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3,
  parameter int unsigned DATA_W = 116
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              of_lookup_req,
  input  logic [DATA_W-1:0] of_lookup_data,
  output logic              of_lookup_busy,
  output logic              of_lookup_ack,
  output logic              of_lookup_err,
  output logic [NPORT-1:0]  of_lookup_fwd_port,
  input  logic              tbl_we,
  input  logic [AW-1:0]     tbl_addr,
  input  logic              tbl_valid,
  input  logic [31:0]       tbl_key,
  input  logic [31:0]       tbl_mask,
  input  logic [NPORT-1:0]  tbl_port,
  output logic [31:0]       stat_lookup_cnt,
  output logic [31:0]       stat_miss_cnt,
  output logic [31:0]       stat_drop_cnt
);

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_e;

  state_e state_q, state_d;

  logic [DEPTH-1:0] tv_q, tv_d;
  logic [31:0]      tk_q [DEPTH];
  logic [31:0]      tk_d [DEPTH];
  logic [31:0]      tm_q [DEPTH];
  logic [31:0]      tm_d [DEPTH];
  logic [NPORT-1:0] tp_q [DEPTH];
  logic [NPORT-1:0] tp_d [DEPTH];

  logic [31:0]      ip_q, ip_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [NPORT-1:0] fwd_q, fwd_d;
  logic [31:0]      look_cnt_q, look_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;
  logic [31:0]      drop_cnt_q, drop_cnt_d;

  logic hit_c;
  logic last_c;
  logic unused_key_bits_c;

  // Only the dst IP participates in matching.
  assign unused_key_bits_c = ^of_lookup_data[DATA_W-1:32];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign hit_c  = tv_q[idx_q] && (((ip_q ^ tk_q[idx_q]) & tm_q[idx_q]) == 32'd0);
  assign last_c = (32'(idx_q) == DEPTH - 32'd1);

  // Table write port; an entry read this cycle still sees its old contents.
  always_comb begin
    tv_d = tv_q;
    tk_d = tk_q;
    tm_d = tm_q;
    tp_d = tp_q;
    if (tbl_we && (32'(tbl_addr) < DEPTH)) begin
      tv_d[tbl_addr] = tbl_valid;
      tk_d[tbl_addr] = tbl_key;
      tm_d[tbl_addr] = tbl_mask;
      tp_d[tbl_addr] = tbl_port;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      tv_q       <= '0;
      ip_q       <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      fwd_q      <= '0;
      look_cnt_q <= '0;
      miss_cnt_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tk_q[i] <= '0;
        tm_q[i] <= '0;
        tp_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tv_q       <= tv_d;
      tk_q       <= tk_d;
      tm_q       <= tm_d;
      tp_q       <= tp_d;
      ip_q       <= ip_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      fwd_q      <= fwd_d;
      look_cnt_q <= look_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (of_lookup_req) state_d = SEARCH;
      SEARCH:  if (hit_c || last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; the search ends on first hit or last entry.
  always_comb begin
    ip_d       = ip_q;
    idx_d      = idx_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    fwd_d      = fwd_q;
    look_cnt_d = look_cnt_q;
    miss_cnt_d = miss_cnt_q;
    drop_cnt_d = drop_cnt_q;
    busy_d     = (state_d == SEARCH);
    unique case (state_q)
      IDLE: begin
        if (of_lookup_req) begin
          ip_d       = of_lookup_data[31:0];
          idx_d      = '0;
          look_cnt_d = sat_inc(look_cnt_q);
        end
      end
      SEARCH: begin
        if (of_lookup_req) drop_cnt_d = sat_inc(drop_cnt_q);
        if (hit_c) begin
          ack_d = 1'b1;
          fwd_d = tp_q[idx_q];
        end else if (last_c) begin
          ack_d      = 1'b1;
          err_d      = 1'b1;
          fwd_d      = '0;
          miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: ;
    endcase
  end

  assign of_lookup_busy     = busy_q;
  assign of_lookup_ack      = ack_q;
  assign of_lookup_err      = err_q;
  assign of_lookup_fwd_port = fwd_q;
  assign stat_lookup_cnt    = look_cnt_q;
  assign stat_miss_cnt      = miss_cnt_q;
  assign stat_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_lookupflow_tbl.sv
// Directed bench for lookupflow_tbl: latency, priority, wildcard, drops,
// live table updates and mid-search reset, with hand-computed expectations.
module tb_lookupflow_tbl;

  localparam int unsigned NPORT  = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned DATA_W = 116;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              of_lookup_req;
  logic [DATA_W-1:0] of_lookup_data;
  logic              of_lookup_busy;
  logic              of_lookup_ack;
  logic              of_lookup_err;
  logic [NPORT-1:0]  of_lookup_fwd_port;
  logic              tbl_we;
  logic [AW-1:0]     tbl_addr;
  logic              tbl_valid;
  logic [31:0]       tbl_key;
  logic [31:0]       tbl_mask;
  logic [NPORT-1:0]  tbl_port;
  logic [31:0]       stat_lookup_cnt;
  logic [31:0]       stat_miss_cnt;
  logic [31:0]       stat_drop_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_look = 0;
  int exp_miss = 0;
  int exp_drop = 0;

  always #5 sys_clk = ~sys_clk;

  lookupflow_tbl #(.NPORT(NPORT), .DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .of_lookup_req(of_lookup_req), .of_lookup_data(of_lookup_data),
    .of_lookup_busy(of_lookup_busy), .of_lookup_ack(of_lookup_ack),
    .of_lookup_err(of_lookup_err), .of_lookup_fwd_port(of_lookup_fwd_port),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_valid(tbl_valid),
    .tbl_key(tbl_key), .tbl_mask(tbl_mask), .tbl_port(tbl_port),
    .stat_lookup_cnt(stat_lookup_cnt), .stat_miss_cnt(stat_miss_cnt),
    .stat_drop_cnt(stat_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input int a, input logic v, input logic [31:0] k, input logic [31:0] m,
                    input logic [NPORT-1:0] p);
    tbl_we = 1'b1; tbl_addr = AW'(a); tbl_valid = v;
    tbl_key = k; tbl_mask = m; tbl_port = p;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ip);
    of_lookup_req  = 1'b1;
    of_lookup_data = '1;
    of_lookup_data[31:0] = ip;
    step();
    of_lookup_req = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (of_lookup_ack !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_lookcnt"}, stat_lookup_cnt, 32'(exp_look));
    chk({tag, "_misscnt"}, stat_miss_cnt, 32'(exp_miss));
    chk({tag, "_dropcnt"}, stat_drop_cnt, 32'(exp_drop));
  endtask

  task automatic lookup(input string tag, input logic [31:0] ip, input int exp_lat,
                        input logic exp_err, input logic [NPORT-1:0] exp_fwd);
    int n;
    issue(ip);
    exp_look++;
    if (exp_err) exp_miss++;
    chk({tag, "_busy"}, 32'(of_lookup_busy), 32'd1);
    wait_ack(n);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_err"}, 32'(of_lookup_err), 32'(exp_err));
    chk({tag, "_fwd"}, 32'(of_lookup_fwd_port), 32'(exp_fwd));
    chk({tag, "_busy_ack"}, 32'(of_lookup_busy), 32'd0);
    step();
    chk({tag, "_ack_pulse"}, 32'(of_lookup_ack), 32'd0);
    chk({tag, "_err_pulse"}, 32'(of_lookup_err), 32'd0);
    chk({tag, "_fwd_hold"}, 32'(of_lookup_fwd_port), 32'(exp_fwd));
    chk_counters(tag);
  endtask

  initial begin
    int n;
    int acks;
    sys_rst_n = 1'b0; of_lookup_req = 1'b0; of_lookup_data = '0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_valid = 1'b0;
    tbl_key = '0; tbl_mask = '0; tbl_port = '0;
    step(); step();
    chk("rst_busy", 32'(of_lookup_busy), 32'd0);
    chk("rst_ack", 32'(of_lookup_ack), 32'd0);
    chk("rst_fwd", 32'(of_lookup_fwd_port), 32'd0);
    chk_counters("rst");
    sys_rst_n = 1'b1;
    step();

    // 1: empty table misses after DEPTH cycles
    lookup("t1_miss", 32'h0A00_0001, 8, 1'b1, 4'b0000);

    // 2: exact /32 at e0, /24 at e3
    wr(0, 1'b1, 32'h0A00_0001, 32'hFFFF_FFFF, 4'b0001);
    wr(3, 1'b1, 32'h0A00_0000, 32'hFFFF_FF00, 4'b1111);
    lookup("t2_e0", 32'h0A00_0001, 1, 1'b0, 4'b0001);
    lookup("t2_e3", 32'h0A00_0009, 4, 1'b0, 4'b1111);

    // 3: wildcard at e1 wins over exact e5; then port-0 drop rule at e2
    wr(1, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'b0100);
    wr(5, 1'b1, 32'h0A00_0002, 32'hFFFF_FFFF, 4'b0010);
    lookup("t3_prio", 32'h0A00_0002, 2, 1'b0, 4'b0100);
    wr(1, 1'b0, 32'h0, 32'h0, 4'b0000);
    wr(2, 1'b1, 32'h0A00_0002, 32'hFFFF_FFFF, 4'b0000);
    lookup("t3_drop_rule", 32'h0A00_0002, 3, 1'b0, 4'b0000);
    wr(2, 1'b0, 32'h0, 32'h0, 4'b0000);
    lookup("t3_e3", 32'h0A00_0002, 4, 1'b0, 4'b1111);

    // 4: req while busy is dropped; req in the ack cycle is accepted
    issue(32'h0A00_0009);
    exp_look++;
    step();
    of_lookup_req = 1'b1;
    step();
    of_lookup_req = 1'b0;
    exp_drop++;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (of_lookup_ack === 1'b1) acks++;
    end
    chk("t4_one_ack", 32'(acks), 32'd1);
    chk("t4_fwd", 32'(of_lookup_fwd_port), 32'hF);
    chk_counters("t4_drop");
    issue(32'h0A00_0009);
    exp_look++;
    wait_ack(n);
    chk("t4_first_lat", 32'(n), 32'd4);
    issue(32'h0A00_0001);
    exp_look++;
    chk("t4_b2b_busy", 32'(of_lookup_busy), 32'd1);
    chk("t4_b2b_ack_low", 32'(of_lookup_ack), 32'd0);
    wait_ack(n);
    chk("t4_b2b_lat", 32'(n), 32'd1);
    chk("t4_b2b_fwd", 32'(of_lookup_fwd_port), 32'h1);
    step();
    chk_counters("t4_b2b");

    // 5: entries written during a search: ahead of idx match, behind do not
    wr(3, 1'b0, 32'h0, 32'h0, 4'b0000);
    issue(32'h0A00_0007);
    exp_look++;
    step();
    wr(4, 1'b1, 32'h0A00_0007, 32'hFFFF_FFFF, 4'b1000);
    wr(0, 1'b1, 32'h0A00_0007, 32'hFFFF_FFFF, 4'b0001);
    chk("t5_busy", 32'(of_lookup_busy), 32'd1);
    wait_ack(n);
    chk("t5_lat", 32'(n), 32'd2);
    chk("t5_err", 32'(of_lookup_err), 32'd0);
    chk("t5_fwd", 32'(of_lookup_fwd_port), 32'h8);
    step();
    chk_counters("t5");

    // 6: reset mid-search aborts it and clears table and counters
    issue(32'h0A00_00FF);
    step(); step();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    exp_look = 0; exp_miss = 0; exp_drop = 0;
    chk("t6_busy", 32'(of_lookup_busy), 32'd0);
    chk("t6_fwd", 32'(of_lookup_fwd_port), 32'd0);
    chk_counters("t6_rst");
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (of_lookup_ack === 1'b1) acks++;
    end
    chk("t6_no_ack", 32'(acks), 32'd0);
    lookup("t6_tbl_clear", 32'h0A00_0007, 8, 1'b1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
